instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch.sv | 110 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory port, hazard/redirect controls and the IF/ID handshake.
interface instruction_fetch_if #(
   parameter int WORD_SIZE = 32
);
   logic [WORD_SIZE-1:0] imem_pc;
   logic [WORD_SIZE-1:0] imem_instr;
   logic                 stall;
   logic                 redirect_valid;
   logic [WORD_SIZE-1:0] redirect_pc;
   logic                 id_valid;
   logic                 id_ready;
   logic [WORD_SIZE-1:0] id_instr;
   logic [WORD_SIZE-1:0] id_pc;
   logic                 halted;

   // IF/ID handshake: a transfer happens on a rising edge where id_valid and id_ready are both
   // high; while id_valid is high and id_ready low, id_instr/id_pc are held stable.
   modport master (
      output imem_pc, id_valid, id_instr, id_pc, halted,
      input  imem_instr, stall, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_pc, id_valid, id_instr, id_pc, halted,
      output imem_instr, stall, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALTED FSM and IF/ID pipeline register.
// Optional macro FETCH_PERF_EN adds fetch_count/stall_count performance counters.
module instruction_fetch #(
   parameter int                   WORD_SIZE  = 32,
   parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
   parameter logic [WORD_SIZE-1:0] HALT_INSTR = '1
) (
   input  logic                clk,
   input  logic                rst_n,
   instruction_fetch_if.master fif,
   output logic [1:0]          state_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]         fetch_count,
   output logic [31:0]         stall_count
`endif
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [WORD_SIZE-1:0] pc_q, pc_d;
   logic [WORD_SIZE-1:0] id_instr_q, id_instr_d;
   logic [WORD_SIZE-1:0] id_pc_q, id_pc_d;
   logic                 id_valid_q, id_valid_d;
   logic                 fire;

   assign fire = (state_q == RUN) && !fif.stall && !fif.redirect_valid &&
                 (!id_valid_q || fif.id_ready);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_valid_d = id_valid_q;
      // Redirect wins over stall, fire and halt; it also flushes IF/ID.
      if (fif.redirect_valid) begin
         pc_d       = fif.redirect_pc & ~WORD_SIZE'(3);
         id_valid_d = 1'b0;
         state_d    = RUN;
      end else begin
         if (fire) begin
            id_instr_d = fif.imem_instr;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            if (fif.imem_instr == HALT_INSTR) begin
               state_d = HALTED;
            end else begin
               pc_d = pc_q + WORD_SIZE'(4);
            end
         end else if (id_valid_q && fif.id_ready) begin
            id_valid_d = 1'b0;
         end
         if (state_q == BOOT) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         id_instr_q <= '0;
         id_pc_q    <= '0;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign fif.imem_pc  = pc_q;
   assign fif.id_valid = id_valid_q;
   assign fif.id_instr = id_instr_q;
   assign fif.id_pc    = id_pc_q;
   assign fif.halted   = (state_q == HALTED);
   assign state_o      = state_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;
   logic        idle_run;

   // A RUN cycle that neither fetches nor redirects counts as a stall cycle.
   assign idle_run = (state_q == RUN) && !fire && !fif.redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (fire)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (idle_run) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

endmodule
